i2c_master: RTL and testbench

Byte-level I2C master engine driving the codec control bus (AK4619) through open-drain pins. It accepts one byte command at a time from an upstream configuration sequencer, optionally framed by START/repeated-START and STOP. It returns the slave's ACK/NACK for every byte. It replaces free-running, ACK-blind bit generation with quarter-phase timing, ACK sampling and clock-stretch support.

---
 rtl/i2c_master_pkg.sv | 61 ++++++
 rtl/i2c_master_sync2.sv | 26 ++
 rtl/i2c_master.sv | 164 ++++++++++++++++
 tb/tb_i2c_master.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_pkg.sv
// Shared definitions for the byte-level I2C master: FSM encodings, quarter
// indices, defaults and the per-state SCL/SDA drive table.
package i2c_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4,
    ST_HOLD  = 3'd5
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int         DEFAULT_CLK_DIV = 16;
  localparam logic [6:0] CODEC_ADDR      = 7'h10;

  // 1 = pull the line low
  typedef struct packed {
    logic scl;
    logic sda;
  } line_t;

  // Open-drain drive for a given state/quarter; a START entered from HOLD keeps SCL low in Q0.
  function automatic line_t line_drive(input state_e st, input logic [1:0] q,
                                       input logic data_bit, input logic from_hold);
    line_t l;
    case (st)
      ST_START: begin
        l.scl = from_hold && (q == Q0);
        l.sda = (q == Q2) || (q == Q3);
      end
      ST_BIT: begin
        l.scl = (q == Q0) || (q == Q1);
        l.sda = ~data_bit;
      end
      ST_ACK: begin
        l.scl = (q == Q0) || (q == Q1);
        l.sda = 1'b0;
      end
      ST_STOP: begin
        l.scl = (q == Q0) || (q == Q1);
        l.sda = (q != Q3);
      end
      ST_HOLD: begin
        l.scl = 1'b1;
        l.sda = 1'b0;
      end
      default: begin
        l.scl = 1'b0;
        l.sda = 1'b0;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/i2c_master_sync2.sv
// Two-flop synchronizer for an asynchronous bus pin; resets to the idle
// (released, high) bus level.
module i2c_master_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Double-register the pin level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/i2c_master.sv
// Byte-level I2C master: one command byte per transaction with optional
// START/repeated-START and STOP, quarter-phase SCL, ACK sampling, clock stretching.
module i2c_master
  import i2c_master_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic [7:0] cmd_byte,
  output logic       rsp_valid,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam int             CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DIV_ONE  = CW'(1);
  localparam logic [CW-1:0] DIV_ZERO = CW'(0);

  logic scl_sync_s;
  logic sda_sync_s;

  i2c_master_sync2 u_scl_sync (.clk(clk), .rst(rst), .d(scl_i), .q(scl_sync_s));
  i2c_master_sync2 u_sda_sync (.clk(clk), .rst(rst), .d(sda_i), .q(sda_sync_s));

  state_e        state_r, state_s;
  logic [1:0]    quarter_r, quarter_s;
  logic [CW-1:0] div_r, div_s;
  logic [2:0]    bit_r, bit_s;
  logic [7:0]    shift_r, shift_s;
  logic          stop_r, stop_s;
  logic          rstart_r, rstart_s;
  logic          quarter_end_s;

  logic  scl_oe_r, sda_oe_r, cmd_ready_r, rsp_valid_r, rsp_nack_r, busy_r;
  line_t drive_s;
  logic  cmd_ready_s, busy_s, rsp_valid_s;

  // Q2 cannot end until the slave has released SCL.
  assign quarter_end_s = (div_r == DIV_LAST) && ((quarter_r != Q2) || scl_sync_s);

  // State, counters, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      quarter_r   <= Q0;
      div_r       <= DIV_ZERO;
      bit_r       <= 3'd0;
      shift_r     <= 8'h00;
      stop_r      <= 1'b0;
      rstart_r    <= 1'b0;
      scl_oe_r    <= 1'b0;
      sda_oe_r    <= 1'b0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_nack_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      quarter_r   <= quarter_s;
      div_r       <= div_s;
      bit_r       <= bit_s;
      shift_r     <= shift_s;
      stop_r      <= stop_s;
      rstart_r    <= rstart_s;
      scl_oe_r    <= drive_s.scl;
      sda_oe_r    <= drive_s.sda;
      cmd_ready_r <= cmd_ready_s;
      rsp_valid_r <= rsp_valid_s;
      busy_r      <= busy_s;
      if ((state_r == ST_ACK) && (quarter_r == Q3) && (div_r == DIV_ZERO)) begin
        rsp_nack_r <= sda_sync_s;
      end else begin
        rsp_nack_r <= rsp_nack_r;
      end
    end
  end

  // Next state and counters.
  always_comb begin
    state_s   = state_r;
    quarter_s = quarter_r;
    div_s     = div_r;
    bit_s     = bit_r;
    shift_s   = shift_r;
    stop_s    = stop_r;
    rstart_s  = rstart_r;
    case (state_r)
      ST_IDLE, ST_HOLD: begin
        if (cmd_valid && cmd_ready_r) begin
          shift_s   = cmd_byte;
          stop_s    = cmd_stop;
          rstart_s  = (state_r == ST_HOLD);
          quarter_s = Q0;
          div_s     = DIV_ZERO;
          bit_s     = 3'd0;
          if ((state_r == ST_IDLE) || cmd_start) begin
            state_s = ST_START;
          end else begin
            state_s = ST_BIT;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_START, ST_BIT, ST_ACK, ST_STOP: begin
        if (!quarter_end_s) begin
          if (div_r != DIV_LAST) begin
            div_s = div_r + DIV_ONE;
          end else begin
            div_s = div_r;
          end
        end else begin
          div_s     = DIV_ZERO;
          quarter_s = quarter_r + 2'd1;
          if (quarter_r == Q3) begin
            case (state_r)
              ST_START: state_s = ST_BIT;
              ST_BIT: begin
                shift_s = {shift_r[6:0], 1'b0};
                if (bit_r == 3'd7) begin
                  state_s = ST_ACK;
                  bit_s   = 3'd0;
                end else begin
                  bit_s   = bit_r + 3'd1;
                end
              end
              ST_ACK:  state_s = stop_r ? ST_STOP : ST_HOLD;
              default: state_s = ST_IDLE;
            endcase
          end else begin
            state_s = state_r;
          end
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change with it.
  always_comb begin
    drive_s     = line_drive(state_s, quarter_s, shift_s[7], rstart_s);
    cmd_ready_s = (state_s == ST_IDLE) || (state_s == ST_HOLD);
    busy_s      = (state_s != ST_IDLE);
    rsp_valid_s = (state_s == ST_ACK) && (quarter_s == Q3) && (div_s == DIV_LAST);
  end

  assign scl_oe    = scl_oe_r;
  assign sda_oe    = sda_oe_r;
  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_nack  = rsp_nack_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: open-drain bus with pull-ups, a bus monitor
// and a small byte-receiving slave that ACKs, stretches and can be absent.
module tb_i2c_master;
  import i2c_master_pkg::*;

  localparam int CD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid, cmd_start, cmd_stop;
  logic [7:0] cmd_byte;
  logic       cmd_ready, rsp_valid, rsp_nack, busy, scl_oe, sda_oe;
  logic       slv_scl_low = 1'b0;
  logic       slv_sda_low = 1'b0;
  logic       ack_en = 1'b1;
  logic       scl_w, sda_w;

  assign scl_w = ~(scl_oe | slv_scl_low);
  assign sda_w = ~(sda_oe | slv_sda_low);

  always #5 clk = ~clk;

  i2c_master #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start),
    .cmd_stop(cmd_stop), .cmd_byte(cmd_byte),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .busy(busy),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl_w), .sda_i(sda_w)
  );

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_start = 0;
  int         n_stop = 0;
  int         n_rsp = 0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic [3:0] slv_bits = 4'd0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_log [0:15];
  logic [3:0] rx_n = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and slave, sampled mid-cycle.
  always @(negedge clk) begin
    if (prev_scl && scl_w && prev_sda && !sda_w) begin
      n_start     <= n_start + 1;
      slv_bits    <= 4'd0;
      slv_sda_low <= 1'b0;
    end else if (prev_scl && scl_w && !prev_sda && sda_w) begin
      n_stop   <= n_stop + 1;
      slv_bits <= 4'd0;
    end else if (!prev_scl && scl_w) begin
      if (slv_bits < 4'd8) begin
        rx_sh    <= {rx_sh[6:0], sda_w};
        slv_bits <= slv_bits + 4'd1;
        if (slv_bits == 4'd7) begin
          rx_log[rx_n] <= {rx_sh[6:0], sda_w};
          rx_n         <= rx_n + 4'd1;
        end
      end else if (slv_bits == 4'd8) begin
        slv_bits <= 4'd9;
      end
    end else if (prev_scl && !scl_w) begin
      if (slv_bits == 4'd8) begin
        slv_sda_low <= ack_en;
      end else if (slv_bits == 4'd9) begin
        slv_sda_low <= 1'b0;
        slv_bits    <= 4'd0;
      end
    end
    if (rsp_valid) n_rsp <= n_rsp + 1;
    prev_scl <= scl_w;
    prev_sda <= sda_w;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns the cycle count seen just after the accept edge.
  task automatic send(input logic s, input logic p, input logic [7:0] b, output int acc);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_start = s; cmd_stop = p; cmd_byte = b;
    while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
    if (!cmd_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    acc = cyc;
  endtask

  task automatic wait_rsp(output int t);
    int n;
    n = 0;
    while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
    if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    t = cyc;
  endtask

  task automatic wait_ready(output int t);
    int n;
    n = 0;
    while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
    if (!cmd_ready) check("ready_timeout", 32'd0, 32'd1);
    t = cyc;
  endtask

  task automatic xfer(input logic s, input logic p, input logic [7:0] b,
                      input logic exp_nack, input int exp_lat);
    int acc, tr, tq;
    send(s, p, b, acc);
    wait_rsp(tr);
    check("rsp_nack", 32'(rsp_nack), 32'(exp_nack));
    wait_ready(tq);
    check("latency", 32'(tq - acc), 32'(exp_lat));
    check("rsp_lead", 32'(tq - tr), p ? 32'(4 * CD + 1) : 32'd1);
    if (ack_en) check("rx_byte", 32'(rx_log[rx_n - 4'd1]), 32'(b));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int s0, p0, r0, acc, tr, tq, n;
    cmd_valid = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_scl_oe", 32'(scl_oe), 32'd0);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_nack", 32'(rsp_nack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Codec address write with START and STOP, slave ACKs.
    s0 = n_start; p0 = n_stop;
    xfer(1'b1, 1'b1, {CODEC_ADDR, 1'b0}, 1'b0, 44 * CD);
    check("t1_starts", 32'(n_start - s0), 32'd1);
    check("t1_stops", 32'(n_stop - p0), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);

    // No slave: NACK, STOP still issued.
    ack_en = 1'b0;
    p0 = n_stop;
    xfer(1'b1, 1'b1, 8'hA5, 1'b1, 44 * CD);
    check("t2_stops", 32'(n_stop - p0), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    ack_en = 1'b1;

    // Three bytes back-to-back, one START and one STOP.
    s0 = n_start; p0 = n_stop; r0 = n_rsp;
    xfer(1'b1, 1'b0, 8'h20, 1'b0, 40 * CD);
    check("t3_hold_scl0", 32'(scl_w), 32'd0);
    xfer(1'b0, 1'b0, 8'h00, 1'b0, 36 * CD);
    check("t3_hold_scl1", 32'(scl_w), 32'd0);
    xfer(1'b0, 1'b1, 8'h37, 1'b0, 40 * CD);
    check("t3_starts", 32'(n_start - s0), 32'd1);
    check("t3_stops", 32'(n_stop - p0), 32'd1);
    check("t3_rsps", 32'(n_rsp - r0), 32'd3);

    // Repeated START from HOLD.
    xfer(1'b1, 1'b0, 8'h20, 1'b0, 40 * CD);
    s0 = n_start; p0 = n_stop;
    send(1'b1, 1'b1, 8'h21, acc);
    wait_rsp(tr);
    check("t4_rstart", 32'(n_start - s0), 32'd1);
    check("t4_no_stop", 32'(n_stop - p0), 32'd0);
    wait_ready(tq);
    check("t4_latency", 32'(tq - acc), 32'(44 * CD));
    check("t4_stops", 32'(n_stop - p0), 32'd1);
    check("t4_rx", 32'(rx_log[rx_n - 4'd1]), 32'h21);

    // Slave stretches SCL for 50 clocks from the start of bit 3 Q2.
    fork
      xfer(1'b1, 1'b1, 8'h20, 1'b0, 44 * CD + 48);
      begin
        int k;
        k = 0;
        while (!(slv_bits == 4'd3 && !scl_w) && k < 2000) begin @(negedge clk); k++; end
        repeat (2 * CD - 1) @(negedge clk);
        slv_scl_low = 1'b1;
        repeat (50) @(negedge clk);
        slv_scl_low = 1'b0;
      end
    join

    // Reset during bit 5 releases the bus at once; a new command starts afresh.
    send(1'b1, 1'b1, 8'h37, acc);
    n = 0;
    while (!(slv_bits == 4'd5 && !scl_w) && n < 2000) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    check("t6_scl_oe", 32'(scl_oe), 32'd0);
    check("t6_sda_oe", 32'(sda_oe), 32'd0);
    check("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    s0 = n_start;
    xfer(1'b1, 1'b1, 8'h20, 1'b0, 44 * CD);
    check("t6_starts", 32'(n_start - s0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
